// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - funct3 opcode constants and the valid opcode range
//   - control state enum (IDLE/BUSY/DONE)
//   - opcode decode helpers (divide family, remainder, high half, operand signedness)
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [2:0] OP_MIN    = OP_MUL;
  localparam logic [2:0] OP_MAX    = OP_REMU;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // DIV/DIVU/REM/REMU
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM/REMU
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MULH/MULHSU/MULHU
  function automatic logic is_high(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  // MUL only needs the low half, which is sign-agnostic, so it is treated as unsigned.
  function automatic logic op0_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: restoring divider datapath on unsigned magnitudes.
//   clk, rst      : clock, async active-high reset
//   start         : load dividend/divisor, clear remainder and step count
//   step          : perform one iteration (registers take quo_nxt/rem_nxt)
//   dividend/divisor : unsigned operand magnitudes
//   quo_nxt/rem_nxt  : combinational result of the current iteration
//   done          : high during the step that produces the final quotient/remainder
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt,
  output logic            done
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted, diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    done = step && (cnt_q == CW'(XLEN-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RISC-V M-extension multiply/divide unit.
//   clk, rst   : clock, async active-high reset
//   flush      : abort in-flight/pending operation (highest priority)
//   req_valid/req_ready, req_opcode (funct3), req_op0 (rs1), req_op1 (rs2)
//   rsp_valid/rsp_ready, rsp_data
// Shift-add multiplier and mdu_divider run XLEN iterations; divide-by-zero and
// signed overflow finish immediately. Optional macro CORE_MDU_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle product.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_op0,
  input  logic [XLEN-1:0] req_op1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data
);
  localparam int CW = $clog2(XLEN);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q, prod_nxt, mul_full;
  logic [XLEN:0]     psum;

  logic              sign0, sign1, neg_acc, accept, last;
  logic              div_zero, div_ovf, special, fast;
  logic [XLEN-1:0]   mag0, mag1, special_val, fast_val, res_sel;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_c, rem_c;
  logic              div_done, div_start, div_step;

  // ---------------- accept-time decode ----------------
  always_comb begin
    sign0    = op0_signed(req_opcode) & req_op0[XLEN-1];
    sign1    = op1_signed(req_opcode) & req_op1[XLEN-1];
    mag0     = sign0 ? -req_op0 : req_op0;
    mag1     = sign1 ? -req_op1 : req_op1;
    // remainder follows the dividend; quotient and products follow sign0^sign1
    neg_acc  = is_rem(req_opcode) ? sign0 : (sign0 ^ sign1);
    div_zero = is_div(req_opcode) && (req_op1 == '0);
    div_ovf  = is_div(req_opcode) && op0_signed(req_opcode) &&
               (req_op0 == {1'b1, {(XLEN-1){1'b0}}}) && (req_op1 == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_val = is_rem(req_opcode) ? req_op0 : '1;
    else          special_val = is_rem(req_opcode) ? '0 : req_op0;
    accept   = (state == S_IDLE) && req_valid && !flush;
  end

`ifdef CORE_MDU_FAST_MUL_EN
  // Operands sign-extended (XLEN+1 significant bits) to 2*XLEN; the low
  // 2*XLEN bits of the product are exact for every signedness combination.
  logic [2*XLEN-1:0] fa, fb, fp;
  always_comb begin
    fa       = {{XLEN{sign0}}, req_op0};
    fb       = {{XLEN{sign1}}, req_op1};
    fp       = fa * fb;
    fast_val = is_high(req_opcode) ? fp[2*XLEN-1:XLEN] : fp[XLEN-1:0];
    fast     = !is_div(req_opcode);
  end
`else
  always_comb begin
    fast_val = '0;
    fast     = 1'b0;
  end
`endif

  // ---------------- iterative datapath ----------------
  always_comb begin
    psum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {psum, prod_q[XLEN-1:1]};
    mul_full = neg_q ? -prod_nxt : prod_nxt;
    quo_c    = neg_q ? -quo_nxt : quo_nxt;
    rem_c    = neg_q ? -rem_nxt : rem_nxt;
    if (is_div(op_q)) res_sel = is_rem(op_q) ? rem_c : quo_c;
    else              res_sel = is_high(op_q) ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    last     = is_div(op_q) ? div_done : (cnt == CW'(XLEN-1));
  end

  assign div_start = accept && is_div(req_opcode) && !special;
  assign div_step  = (state == S_BUSY) && is_div(op_q) && !flush;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag0),
    .divisor  (mag1),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt),
    .done     (div_done)
  );

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = (special || fast) ? S_DONE : S_BUSY;
      end
      S_BUSY: if (last) state_nxt = S_DONE;
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= req_opcode;
      neg_q   <= neg_acc;
      mcand_q <= mag0;
      prod_q  <= {{XLEN{1'b0}}, mag1};
      if (special)   rsp_data <= special_val;
      else if (fast) rsp_data <= fast_val;
    end else if ((state == S_BUSY) && !flush) begin
      cnt    <= (cnt == CW'(XLEN-1)) ? '0 : cnt + 1'b1;
      prod_q <= prod_nxt;
      if (last) rsp_data <= res_sel;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RISC-V M-extension multiply/divide unit, XLEN-parametrised, beside the single-cycle ALU in the execute stage. Accepts one operation per valid/ready handshake, computes over multiple cycles with a shift-add multiplier and a restoring divider, and holds the result until the pipeline takes it. Supports abort on pipeline flush.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  abort any in-flight or pending operation.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; reset value 1.
- req_opcode  in  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- req_op0  in  XLEN  rs1 value.
- req_op1  in  XLEN  rs2 value.
- rsp_valid  out  1  result available; reset value 0.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  XLEN  result; reset value 0.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, iteration counter 0, result register 0.
- IDLE: req_ready=1. Accept when req_valid && !flush. Operands are converted to magnitudes per the signedness of the opcode; result sign is latched.
  - MULHSU: op0 signed, op1 unsigned.
  - DIV/REM: quotient sign = sign0 ^ sign1; remainder sign = sign0.
  - Accept → BUSY, counter 0.
- Special cases on accept go directly to DONE, with no iterations:
  - divisor 0: DIV/DIVU → all ones; REM/REMU → op0.
  - Signed overflow (op0 = 1 followed by zeros, op1 = all ones) for DIV → op0; for REM → 0.
- BUSY: one iteration per cycle, XLEN iterations; counter wraps from XLEN-1 to exit.
  - Multiply: 2·XLEN-bit partial product; add the multiplicand when the multiplier LSB is set, then shift right 1.
  - Divide: shift the remainder/quotient pair left 1; trial-subtract the divisor; keep if non-negative and set quotient LSB.
- On the last iteration, apply sign correction (two's complement if negative) and select the output:
  - MUL: low half.
  - MULH*: high half.
  - DIV*: quotient.
  - REM*: remainder.
  - Register the selected value in rsp_data and go → DONE.
- DONE: rsp_valid=1, rsp_data stable. On rsp_valid && rsp_ready → IDLE. req_ready=0 in DONE.
- flush has highest priority in every state:
  - Next state is IDLE, rsp_valid drops next cycle, and no response is produced.
  - A req in the same cycle as flush is not accepted.
  - A DONE handshake coinciding with flush is discarded.
- Reset mid-operation: immediate return to reset values; no response.

## Timing
- Accept at edge E0. BUSY spans XLEN cycles. rsp_valid is first high in the cycle after edge E0+XLEN: latency XLEN+1 cycles (33 at XLEN=32).
- Special-case divide: rsp_valid in the cycle after E0 (latency 1).
- The earliest next accept is the cycle after the response handshake; no overlap.
- req_ready is a registered-state decode only (IDLE); no combinational path from req_valid.

## Configuration
- CORE_MDU_FAST_MUL_EN defined: multiplies use a single-cycle XLEN×XLEN signed (XLEN+1-bit extended) product. MUL* goes IDLE→DONE with latency 1; divides are unchanged.
- Not defined: all multiplies are iterative, latency XLEN+1. Results are bit-identical in both builds.

## Structure
- The shared core header/package holds:
  - MDU opcode constants and the opcode range.
  - The state enum (IDLE/BUSY/DONE).
  - The is_div / is_rem / is_high / op0_signed / op1_signed decode helpers.
- Sub-module mdu_divider: restoring divide datapath (remainder, quotient, trial subtract) with start/step/done. The multiplier datapath, sign handling, control FSM and handshake live in mdu.

## Test plan
- MUL 7 × 0xFFFFFFFD → rsp_data 0xFFFFFFEB, rsp_valid exactly 33 cycles after accept (1 with CORE_MDU_FAST_MUL_EN).
- 0xFFFFFFFF × 0xFFFFFFFF: MULH → 0x00000000, MULHSU → 0xFFFFFFFF, MULHU → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; each with latency 1.
- Flush at the 10th BUSY cycle → no rsp_valid, req_ready=1 next cycle. A following MULHU 3 × 5 → 0.
- rsp_ready low 5 cycles in DONE → rsp_valid and rsp_data held; rst asserted mid-BUSY → req_ready=1, rsp_valid=0, rsp_data=0 immediately.
